// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shared AXI read-channel arbiter and cache-block refill sequencer
//
// Purpose:
//   Shares one AXI read address/data channel between the icache and the
//   dcache refill paths. One block refill is in flight at a time. It is
//   issued as a single INCR burst of BLK_WORDS 32-bit beats. The beats are
//   assembled into a block buffer, and the block is handed back to the
//   requesting cache with a one-cycle valid pulse.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   ic_ren / ic_raddr        icache refill request and miss address
//   ic_rrdy                  high while a new request can be accepted
//   ic_rvalid / ic_rdata     one-cycle block-valid pulse and block data
//   dc_*                     same set of ports for the dcache
//   arid .. arvalid, arready AXI read address channel (master side)
//   rid, rdata, rresp,       AXI read data channel (master side); rid,
//   rlast, rvalid, rready    rresp and rlast are ignored
//
// Parameters:
//   BLK_WORDS                32-bit words per cache block (power of two, 2..16)

module axi_rd_arbiter #(
    parameter int BLK_WORDS = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    ic_ren,
    input  logic [31:0]             ic_raddr,
    output logic                    ic_rrdy,
    output logic                    ic_rvalid,
    output logic [BLK_WORDS*32-1:0] ic_rdata,

    input  logic                    dc_ren,
    input  logic [31:0]             dc_raddr,
    output logic                    dc_rrdy,
    output logic                    dc_rvalid,
    output logic [BLK_WORDS*32-1:0] dc_rdata,

    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int BEAT_W   = $clog2(BLK_WORDS);
    localparam int ADDR_LSB = $clog2(BLK_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_last_grant;   // 0 = icache, 1 = dcache
    logic                      r_owner;        // 0 = icache, 1 = dcache
    logic                      r_rrdy;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_ic_rvalid;
    logic                      r_dc_rvalid;
    logic [3:0]                r_arid;
    logic [31:0]               r_araddr;
    logic [BEAT_W-1:0]         r_beat;
    logic [BLK_WORDS*32-1:0]   r_buf;

    logic                      w_any_req;
    logic                      w_grant_dc;
    logic [31:0]               w_req_addr;
    logic [31:0]               w_blk_addr;
    logic                      w_beat_fire;
    logic                      w_last_beat;
    logic                      w_unused_bits;

    // On a tie, the dcache wins unless it was the last one granted.
    // Because last_grant resets to icache, the first tie goes to the dcache.
    assign w_any_req   = ic_ren | dc_ren;
    assign w_grant_dc  = dc_ren & (~ic_ren | ~r_last_grant);
    assign w_req_addr  = w_grant_dc ? dc_raddr : ic_raddr;
    assign w_blk_addr  = {w_req_addr[31:ADDR_LSB], {ADDR_LSB{1'b0}}};

    assign w_beat_fire = rvalid & r_rready;
    assign w_last_beat = (r_beat == BEAT_W'(BLK_WORDS - 1));

    // The burst length is counted locally. The ID, response and last
    // qualifiers from the slave are intentionally not used.
    assign w_unused_bits = ^{rid, rresp, rlast, w_req_addr[ADDR_LSB-1:0]};

    // Control FSM. Every handshake and status output is a register, so the
    // cache and AXI sides never see combinational paths through the arbiter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
            r_owner      <= 1'b0;
            r_rrdy       <= 1'b1;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_ic_rvalid  <= 1'b0;
            r_dc_rvalid  <= 1'b0;
            r_arid       <= 4'd0;
            r_araddr     <= 32'd0;
            r_beat       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_grant_dc;
                        r_arid    <= {3'b000, w_grant_dc};
                        r_araddr  <= w_blk_addr;
                        r_beat    <= '0;
                        r_arvalid <= 1'b1;
                        r_rrdy    <= 1'b0;
                        r_state   <= S_AR;
                    end
                end

                S_AR: begin
                    // arid and araddr stay frozen until the slave takes them.
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end

                S_R: begin
                    if (w_beat_fire) begin
                        if (w_last_beat) begin
                            // The counter does not advance on the final beat,
                            // so it never wraps inside a burst.
                            r_rready    <= 1'b0;
                            r_ic_rvalid <= ~r_owner;
                            r_dc_rvalid <= r_owner;
                            r_state     <= S_DONE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_ic_rvalid  <= 1'b0;
                    r_dc_rvalid  <= 1'b0;
                    r_last_grant <= r_owner;
                    r_rrdy       <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Block buffer: each accepted beat lands in the word selected by the
    // beat counter. The buffer keeps its contents until the next burst
    // overwrites them.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_buf <= '0;
        end else begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                if (w_beat_fire && (r_beat == BEAT_W'(i))) begin
                    r_buf[i*32 +: 32] <= rdata;
                end
            end
        end
    end

    assign ic_rrdy   = r_rrdy;
    assign dc_rrdy   = r_rrdy;
    assign ic_rvalid = r_ic_rvalid;
    assign dc_rvalid = r_dc_rvalid;
    assign ic_rdata  = r_buf;
    assign dc_rdata  = r_buf;

    assign arid      = r_arid;
    assign araddr    = r_araddr;
    assign arlen     = 8'(BLK_WORDS - 1);
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter and refill sequencer that shares the single AXI read address/data channel between the instruction cache and the data cache. It accepts one cache-block refill request at a time and issues it as a single INCR burst. It assembles the returned beats into a full cache block and hands the block back to the requesting cache with a one-cycle valid pulse. It sits between the cache miss interfaces and the AXI master's AR/R channels.

## Interface
- BLK_WORDS, 8, 32-bit words per cache block (power of two, 2..16)
- aclk  in  1  clock
- aresetn  in  1  asynchronous reset, active low
- ic_ren  in  1  icache refill request
- ic_raddr  in  32  icache miss address
- ic_rrdy  out  1  arbiter can accept an icache request this cycle
- ic_rvalid  out  1  one-cycle pulse, block on ic_rdata is valid
- ic_rdata  out  BLK_WORDS*32  refill block, word 0 in bits [31:0]
- dc_ren, dc_raddr, dc_rrdy, dc_rvalid, dc_rdata: same as ic_*, for the dcache
- arid  out  4  0 = icache, 1 = dcache
- araddr  out  32  block-aligned burst address
- arlen  out  8  constant BLK_WORDS-1
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rid  in  4  ignored; one outstanding burst only
- rdata  in  32  beat data
- rresp  in  2  ignored
- rlast  in  1  ignored; beat count ends the burst
- rvalid  in  1  beat valid
- rready  out  1  beat accepted

## Operation
- States: IDLE, AR, R, DONE.
- IDLE
  - ic_rrdy = dc_rrdy = 1; all other control outputs are 0.
  - A request is accepted at the clock edge where ren=1 in IDLE.
- Arbitration
  - Only one requester active: that requester is granted.
  - Both active: round-robin. The requester not granted last time wins.
  - last_grant resets to icache, so the first tie goes to the dcache.
- On grant:
  - latch owner;
  - latch the address with its low log2(BLK_WORDS*4) bits cleared;
  - clear the beat counter;
  - go to AR.
- AR: arvalid=1 with arid and araddr held stable. On arvalid&&arready, go to R.
- R
  - rready=1.
  - Each rvalid&&rready writes rdata into buffer word [beat], then beat increments.
  - The beat with beat==BLK_WORDS-1 is the last; on it, go to DONE.
- DONE
  - Pulse the owner's *_rvalid for exactly one cycle.
  - Update last_grant to the owner and go to IDLE.
- Both ic_rdata and dc_rdata are driven from the shared block buffer. Data is meaningful only while the matching rvalid pulses, and holds until the next burst overwrites it.
- rrdy is 0 in AR, R and DONE. A request held during those states waits and is considered on return to IDLE.
- Beat counter width is log2(BLK_WORDS). It never wraps within a burst.

## Timing
- Reset values:
  - state IDLE, last_grant icache;
  - arvalid, rready, ic_rvalid, dc_rvalid all 0;
  - araddr, arid, buffer all 0;
  - ic_rrdy and dc_rrdy are 1 after reset release.
- Asserting reset at any time, including mid-AR or mid-R, returns to IDLE immediately. The burst is abandoned and no rvalid pulse is issued.
- Request accepted at edge 0 → arvalid high in cycle 1.
- arready in cycle 1 → rready high in cycle 2.
- With zero-wait beats from cycle 2 onward, the last beat lands in cycle 1+BLK_WORDS. rvalid pulses in cycle 2+BLK_WORDS; IDLE in cycle 3+BLK_WORDS.
- Minimum request-to-valid latency: BLK_WORDS+2 cycles.
- Gaps in rvalid stall the counter with no data loss.
- arvalid is never dropped before arready. araddr and arid are constant while arvalid=1.
- A request is never accepted in the same cycle an rvalid pulse is issued. Back-to-back bursts are separated by at least one IDLE cycle.

## Test plan
- Single icache refill:
  - stimulus: ic_raddr=0x1C00_0014, arready immediate, 8 beats 0xA0..0xA7 with no gaps;
  - response: araddr=0x1C00_0000, arid=0, arlen=7; ic_rvalid pulses once, 10 cycles after accept; ic_rdata word i = 0xA0+i; dc_rvalid stays 0.
- Dcache refill with arready delayed 3 cycles and one idle cycle between every beat:
  - arvalid is held with araddr stable for 4 cycles;
  - arid=1;
  - the block is assembled in order;
  - dc_rvalid pulses once.
- Simultaneous requests:
  - stimulus: ic_ren and dc_ren high continuously for three bursts;
  - response: grant order dcache, icache, dcache; each rvalid goes only to its owner.
- Request held while busy:
  - stimulus: ic_ren asserted during a dcache burst;
  - response: ic_rrdy=0 until IDLE; the icache burst starts with arvalid on the cycle after IDLE accept.
- Reset mid-burst:
  - stimulus: aresetn low after beat 3 of 8;
  - response: arvalid, rready and both rvalid are 0 immediately; rrdy=1 after release; the next burst completes correctly.
- rlast and rresp robustness:
  - stimulus: rlast asserted on beat 2, rresp=2'b10 on every beat;
  - response: the transfer still runs all 8 beats before rvalid.
